// File: rtl/ring_station_arb_if.sv
// Station output-link bundle: ring/local FIFO head ports, the downstream link and the current grant.
// The arbiter takes the master modport; FIFOs, the downstream link and the bench take slave.
interface ring_station_arb_if #(
    parameter int WIDTH = 8
);
    logic             iRingEmpty;
    logic [WIDTH-1:0] iRingDat;
    logic             oRingRdEn;
    logic             iLoclEmpty;
    logic [WIDTH-1:0] iLoclDat;
    logic             oLoclRdEn;
    logic             oLinkVld;
    logic [WIDTH-1:0] oLinkDat;
    logic             iLinkRdy;
    logic [1:0]       oLock;

    modport master (
        input  iRingEmpty, iRingDat, iLoclEmpty, iLoclDat, iLinkRdy,
        output oRingRdEn, oLoclRdEn, oLinkVld, oLinkDat, oLock
    );

    modport slave (
        output iRingEmpty, iRingDat, iLoclEmpty, iLoclDat, iLinkRdy,
        input  oRingRdEn, oLoclRdEn, oLinkVld, oLinkDat, oLock
    );
endinterface

// File: rtl/ring_station_arb.sv
// PtRing station output arbiter: wormhole grant between ring pass-through and local injection FIFOs.
// Define RING_ARB_STARVE_EN to add the local starvation counter; without it ring priority is strict.
module ring_station_arb #(
    parameter int WIDTH      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    ring_station_arb_if.master  bus
);
    // Handshake: a flit moves downstream on a cycle where oLinkVld & iLinkRdy; the output
    // register reloads (pop or go empty) whenever it is empty or being accepted that cycle.
    // oLock carries the FSM state directly (the enum encoding equals the grant code).
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOCK_RING  = 2'b01,
        LOCK_LOCAL = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             link_vld_q, link_vld_d;
    logic [WIDTH-1:0] link_dat_q, link_dat_d;

    logic             ld;
    logic             forced;
    logic             sel_ring, sel_locl;
    logic             ring_rd, locl_rd;
    logic [WIDTH-1:0] pop_dat;
    logic             pop_tail;

    assign ld = !link_vld_q | bus.iLinkRdy;

`ifdef RING_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    assign forced = (starve_q == STARVE_LIM) & !bus.iLoclEmpty;

    // Counts whole ring packets that went out while local was waiting.
    always_comb begin
        starve_d = starve_q;
        if (locl_rd & pop_tail) begin
            starve_d = 4'd0;
        end else if (ring_rd & pop_tail & !bus.iLoclEmpty & (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = ^(4'(STARVE_MAX));
    assign forced            = 1'b0;
`endif

    always_comb begin
        sel_ring = 1'b0;
        sel_locl = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.iRingEmpty && !forced) begin
                    sel_ring = 1'b1;
                end else if (!bus.iLoclEmpty) begin
                    sel_locl = 1'b1;
                end
            end
            LOCK_RING:  sel_ring = !bus.iRingEmpty;
            LOCK_LOCAL: sel_locl = !bus.iLoclEmpty;
            default:    ;
        endcase
    end

    // Pops are masked during reset so the FIFOs see no read while rst is high.
    assign ring_rd  = ld & sel_ring & !rst;
    assign locl_rd  = ld & sel_locl & !rst;
    assign pop_dat  = ring_rd ? bus.iRingDat : bus.iLoclDat;
    assign pop_tail = pop_dat[WIDTH-1];

    always_comb begin
        state_d    = state_q;
        link_vld_d = link_vld_q;
        link_dat_d = link_dat_q;
        if (ld) begin
            link_vld_d = ring_rd | locl_rd;
            if (ring_rd | locl_rd) begin
                link_dat_d = pop_dat;
            end
        end
        if (ring_rd) begin
            state_d = pop_tail ? IDLE : LOCK_RING;
        end else if (locl_rd) begin
            state_d = pop_tail ? IDLE : LOCK_LOCAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            link_vld_q <= 1'b0;
            link_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            link_vld_q <= link_vld_d;
            link_dat_q <= link_dat_d;
        end
    end

    assign bus.oRingRdEn = ring_rd;
    assign bus.oLoclRdEn = locl_rd;
    assign bus.oLinkVld  = link_vld_q;
    assign bus.oLinkDat  = link_dat_q;
    assign bus.oLock     = state_q;
endmodule

// File: tb/tb_ring_station_arb.sv
// Bench for ring_station_arb: FIFO contents held as queues, a packet-level grant model, a per-cycle
// compare and an in-order link scoreboard, plus directed scenarios with literal expectations.
module tb_ring_station_arb;
    localparam int W    = 8;
    localparam int SMAX = 4;
`ifdef RING_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy;

    ring_station_arb_if #(.WIDTH(W)) bus ();

    ring_station_arb #(.WIDTH(W), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // upstream FIFO contents and link scoreboard
    logic [W-1:0] ring_q[$];
    logic [W-1:0] locl_q[$];
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // model: owner 0 none / 1 ring / 2 local; starve counts ring packets sent past a waiting local
    int           owner;
    int           starve;
    logic         m_vld;
    logic [W-1:0] m_dat;
    int           m_pick;

    logic [1:0] s_lock;
    logic       s_rrd, s_lrd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.iRingEmpty = (ring_q.size() == 0);
        bus.iRingDat   = (ring_q.size() != 0) ? ring_q[0] : '0;
        bus.iLoclEmpty = (locl_q.size() == 0);
        bus.iLoclDat   = (locl_q.size() != 0) ? locl_q[0] : '0;
        bus.iLinkRdy   = rdy;
    endtask

    task automatic model_reset();
        owner  = 0;
        starve = 0;
        m_vld  = 1'b0;
        m_dat  = '0;
        ring_q.delete();
        locl_q.delete();
        exp_q.delete();
    endtask

    task automatic model_decide();
        bit can_load, force_locl;
        can_load   = !m_vld || rdy;
        force_locl = STARVE_EN && (starve == SMAX) && (locl_q.size() != 0);
        m_pick = 0;
        if (can_load) begin
            if (owner == 1) begin
                if (ring_q.size() != 0) m_pick = 1;
            end else if (owner == 2) begin
                if (locl_q.size() != 0) m_pick = 2;
            end else if (ring_q.size() != 0 && !force_locl) begin
                m_pick = 1;
            end else if (locl_q.size() != 0) begin
                m_pick = 2;
            end
        end
    endtask

    task automatic model_commit();
        bit           can_load, tail;
        logic [W-1:0] f;
        can_load = !m_vld || rdy;
        f = '0;
        if (m_pick == 1) f = ring_q.pop_front();
        else if (m_pick == 2) f = locl_q.pop_front();
        tail = f[W-1];
        if (m_pick != 0) begin
            if (m_pick == 1 && tail && locl_q.size() != 0 && starve < SMAX) starve++;
            if (m_pick == 2 && tail) starve = 0;
            owner = tail ? 0 : m_pick;
            m_vld = 1'b1;
            m_dat = f;
            exp_q.push_back(f);
        end else if (can_load) begin
            m_vld = 1'b0;
        end
    endtask

    // one clock: entered and left at a falling edge
    task automatic cycle();
        logic [W-1:0] head;
        drive();
        #1;
        model_decide();
        s_lock = bus.oLock;
        s_rrd  = bus.oRingRdEn;
        s_lrd  = bus.oLoclRdEn;
        chk("ring_rd", 32'(s_rrd), 32'(m_pick == 1));
        chk("locl_rd", 32'(s_lrd), 32'(m_pick == 2));
        chk("lock", 32'(s_lock), 32'(owner));
        chk("link_vld", 32'(bus.oLinkVld), 32'(m_vld));
        if (m_vld) chk("link_dat", 32'(bus.oLinkDat), 32'(m_dat));
        if (bus.oLinkVld && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow act=%0h exp=none t=%0t", bus.oLinkDat, $time);
            end else begin
                head = exp_q.pop_front();
                chk("sb_order", 32'(bus.oLinkDat), 32'(head));
            end
        end
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdy = 1'b1;
        while ((ring_q.size() != 0 || locl_q.size() != 0 || m_vld) && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_bound", 32'(n < 40), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e_lock[5];
        logic       e_rrd[5];
        logic       e_lrd[5];
        logic [W-1:0] e_dat[4];
        int         loc_pops, first_loc, n;

        // reset with both FIFOs holding a flit
        model_reset();
        rdy = 1'b1;
        rst = 1'b1;
        ring_q.push_back(8'h81);
        locl_q.push_back(8'h82);
        drive();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld", 32'(bus.oLinkVld), 32'd0);
        chk("rst_dat", 32'(bus.oLinkDat), 32'd0);
        chk("rst_lock", 32'(bus.oLock), 32'd0);
        chk("rst_rrd", 32'(bus.oRingRdEn), 32'd0);
        chk("rst_lrd", 32'(bus.oLoclRdEn), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("first_rrd", 32'(s_rrd), 32'd1);
        chk("first_lrd", 32'(s_lrd), 32'd0);
        chk("first_vld", 32'(bus.oLinkVld), 32'd1);
        chk("first_dat", 32'(bus.oLinkDat), 32'h81);
        drain();

        // 3-flit ring packet holds off a waiting local flit
        ring_q.push_back(8'h01);
        ring_q.push_back(8'h02);
        ring_q.push_back(8'h83);
        locl_q.push_back(8'h84);
        e_lock = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        e_rrd  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        e_lrd  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_dat  = '{8'h01, 8'h02, 8'h83, 8'h84};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("pkt_lock", 32'(s_lock), 32'(e_lock[i]));
            chk("pkt_rrd", 32'(s_rrd), 32'(e_rrd[i]));
            chk("pkt_lrd", 32'(s_lrd), 32'(e_lrd[i]));
            if (i < 4) chk("pkt_dat", 32'(bus.oLinkDat), 32'(e_dat[i]));
            else chk("pkt_idle_vld", 32'(bus.oLinkVld), 32'd0);
        end
        drain();

        // backpressure mid-packet
        ring_q.push_back(8'h05);
        ring_q.push_back(8'h06);
        ring_q.push_back(8'h07);
        ring_q.push_back(8'h88);
        cycle();
        cycle();
        chk("bp_pre_dat", 32'(bus.oLinkDat), 32'h06);
        rdy = 1'b0;
        repeat (5) begin
            cycle();
            chk("bp_rrd", 32'(s_rrd), 32'd0);
            chk("bp_lrd", 32'(s_lrd), 32'd0);
            chk("bp_dat", 32'(bus.oLinkDat), 32'h06);
        end
        rdy = 1'b1;
        cycle();
        chk("bp_resume1", 32'(bus.oLinkDat), 32'h07);
        cycle();
        chk("bp_resume2", 32'(bus.oLinkDat), 32'h88);
        chk("bp_resume_rrd", 32'(s_rrd), 32'd1);
        drain();

        // ring saturated with 1-flit packets, local waiting
        loc_pops  = 0;
        first_loc = -1;
        for (int i = 0; i < 20; i++) begin
            while (ring_q.size() < 2) ring_q.push_back(8'h80 | 8'(i));
            while (locl_q.size() < 1) locl_q.push_back(8'hC0 | 8'(i));
            cycle();
            if (s_lrd) begin
                loc_pops++;
                if (first_loc < 0) first_loc = i;
            end
        end
        chk("starve_loc_pops", 32'(loc_pops), STARVE_EN ? 32'd4 : 32'd0);
        chk("starve_first_loc", 32'(first_loc), STARVE_EN ? 32'd4 : 32'hFFFF_FFFF);
        drain();

        // local packet lock survives empty local FIFO while ring waits
        locl_q.push_back(8'h11);
        cycle();
        chk("ll_grant", 32'(s_lrd), 32'd1);
        ring_q.push_back(8'h21);
        ring_q.push_back(8'hA2);
        repeat (3) begin
            cycle();
            chk("ll_no_ring", 32'(s_rrd), 32'd0);
            chk("ll_lock", 32'(s_lock), 32'd2);
        end
        locl_q.push_back(8'h93);
        cycle();
        chk("ll_tail_pop", 32'(s_lrd), 32'd1);
        chk("ll_tail_lock", 32'(s_lock), 32'd2);
        cycle();
        chk("ll_after_lock", 32'(s_lock), 32'd0);
        chk("ll_after_rrd", 32'(s_rrd), 32'd1);
        drain();

        // asynchronous reset mid-packet
        ring_q.push_back(8'h31);
        ring_q.push_back(8'h32);
        ring_q.push_back(8'h33);
        cycle();
        cycle();
        chk("mid_pre_lock", 32'(bus.oLock), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(bus.oLinkVld), 32'd0);
        chk("mid_rst_lock", 32'(bus.oLock), 32'd0);
        chk("mid_rst_dat", 32'(bus.oLinkDat), 32'd0);
        chk("mid_rst_rrd", 32'(bus.oRingRdEn), 32'd0);
        model_reset();
        drive();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("mid_idle", 32'(s_lock), 32'd0);
        ring_q.push_back(8'h85);
        cycle();
        chk("mid_new_pkt", 32'(s_rrd), 32'd1);
        drain();

        // randomized traffic and backpressure
        for (int c = 0; c < 1500; c++) begin
            if (ring_q.size() < 6 && $urandom_range(0, 9) < 3) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) ring_q.push_back({k == n - 1, 7'($urandom_range(0, 127))});
            end
            if (locl_q.size() < 6 && $urandom_range(0, 9) < 3) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) locl_q.push_back({k == n - 1, 7'($urandom_range(0, 127))});
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
        cycle();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_station_arb.md
# ring_station_arb

Output-link arbiter for a PtRing station. Two TwoRegFifo instances feed it: the ring pass-through FIFO and the local-injection FIFO. It pops flits from one FIFO at a time onto the single downstream ring link through a one-entry output register. It holds a grant for a whole wormhole packet, delimited by a tail bit. Ring traffic has priority, and an optional starvation counter guarantees the local source forward progress.

## Interface
- WIDTH, 8: flit width including tail flag; bit [WIDTH-1] = tail, 1 marks last flit of a packet.
- STARVE_MAX, 4: consecutive ring packets granted while local waits before local is forced; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- iRingEmpty  in  1  ring FIFO oEmpty.
- iRingDat  in  WIDTH  ring FIFO head flit; valid when iRingEmpty=0.
- oRingRdEn  out  1  pop ring FIFO this cycle.
- iLoclEmpty  in  1  local FIFO oEmpty.
- iLoclDat  in  WIDTH  local FIFO head flit; valid when iLoclEmpty=0.
- oLoclRdEn  out  1  pop local FIFO this cycle.
- oLinkVld  out  1  output register holds a flit.
- oLinkDat  out  WIDTH  output flit.
- iLinkRdy  in  1  downstream accepts flit when oLinkVld & iLinkRdy.
- oLock  out  2  current grant: 00 none, 01 ring, 10 local.

## Operation
- Load condition: `ld = !oLinkVld | iLinkRdy`. A FIFO is popped only when ld=1 and that FIFO is selected and non-empty.
- At most one of oRingRdEn/oLoclRdEn is high in any cycle. Both are combinational from state, empties and ld. Neither is asserted to an empty FIFO.
- FSM states:
  - IDLE (oLock=00): select by priority rule. A selected pop with tail=0 moves to LOCK_RING or LOCK_LOCAL. A pop with tail=1 (single-flit packet) stays in IDLE.
  - LOCK_RING (01): pop only the ring FIFO. The popped tail=1 flit returns the FSM to IDLE.
  - LOCK_LOCAL (10): same rules for the local FIFO.
- While locked, the other FIFO is never popped. This holds even if the locked FIFO is empty, so bubbles are allowed.
- Priority rule in IDLE:
  - Ring wins when non-empty, unless forced.
  - Local wins when ring is empty, or when forced.
- starveCnt: 4-bit counter, reset 0.
  - Increments when a ring tail flit is popped while iLoclEmpty=0, saturating at STARVE_MAX.
  - Clears when a local tail flit is popped.
  - `forced = (starveCnt == STARVE_MAX) & !iLoclEmpty`.
- Output register:
  - On ld with a pop, it captures the popped flit and sets oLinkVld=1.
  - On ld with no pop, oLinkVld=0.
  - Otherwise oLinkVld and oLinkDat hold.

## Timing
- Reset values: oLinkVld=0, oLinkDat=0, oLock=00, starveCnt=0, FSM=IDLE, oRingRdEn=0, oLoclRdEn=0.
- Latency: a flit popped at edge N appears on oLinkDat/oLinkVld after edge N. Throughput is 1 flit/cycle when iLinkRdy stays 1.
- Backpressure: iLinkRdy=0 with oLinkVld=1 suppresses all pops. The flit holds stable until accepted.
- Simultaneous events:
  - Accepting a flit and loading the next occur in the same cycle, with no bubble.
  - Tail pop and new-packet grant never coincide: the next grant decision is made in the cycle after the tail, from IDLE.
- A packet lock persists across any number of empty cycles of the locked FIFO.
- Asynchronous reset mid-packet returns everything to reset values immediately. A partially sent packet is dropped by the arbiter; upstream FIFOs are reset on the same rst.

## Configuration
- RING_ARB_STARVE_EN defined: starvation counter and forced grant as described.
- Not defined: starveCnt is removed and forced is tied to 0. The result is strict ring priority, and local is granted only in IDLE with the ring FIFO empty.

## Test plan
- Reset with both FIFOs non-empty: all outputs 0 during rst. First cycle after release, oRingRdEn=1, oLoclRdEn=0, then oLinkVld=1 next cycle.
- Ring 3-flit packet (tails 0,0,1), local 1-flit waiting: oLock=01 for 3 pops. No local pop until the ring tail leaves, then local is granted from IDLE.
- iLinkRdy=0 for 5 cycles mid-packet: oLinkDat is unchanged, both RdEn=0, then throughput resumes at 1 flit/cycle.
- RING_ARB_STARVE_EN, STARVE_MAX=4, ring continuously full of 1-flit packets, local non-empty: exactly 4 ring flits, then 1 local flit, repeating. Without the macro, local is never granted.
- Locked local packet whose FIFO empties for 3 cycles while ring is non-empty: ring is not popped and oLock stays 10 until the local tail is popped.
- Assert rst mid-packet: oLinkVld and oLock are 0 within the same cycle, and the FSM is in IDLE after release.
